// File: rtl/axi_compare_monitor.sv
// Status monitor for the AXI compare stage: saturating per-channel mismatch counters, first-mismatch capture, sticky irq and busy-hang watchdog.
// All outputs registered, one cycle after the sampled inputs; no backpressure, every cycle's inputs are consumed.
module axi_compare_monitor #(
  parameter int unsigned AxiIdWidth    = 4,
  parameter int unsigned CntWidth      = 16,
  parameter int unsigned TimeWidth     = 32,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      enable_i,
  input  logic                      clear_i,
  input  logic [2**AxiIdWidth-1:0]  aw_mismatch_i,
  input  logic                      w_mismatch_i,
  input  logic [2**AxiIdWidth-1:0]  b_mismatch_i,
  input  logic [2**AxiIdWidth-1:0]  ar_mismatch_i,
  input  logic [2**AxiIdWidth-1:0]  r_mismatch_i,
  input  logic                      busy_i,
  output logic [CntWidth-1:0]       aw_cnt_o,
  output logic [CntWidth-1:0]       w_cnt_o,
  output logic [CntWidth-1:0]       b_cnt_o,
  output logic [CntWidth-1:0]       ar_cnt_o,
  output logic [CntWidth-1:0]       r_cnt_o,
  output logic                      first_valid_o,
  output logic [2:0]                first_chan_o,
  output logic [AxiIdWidth-1:0]     first_id_o,
  output logic [TimeWidth-1:0]      first_time_o,
  output logic                      irq_o,
  output logic                      hang_o
);

  localparam int unsigned NumIds   = 2**AxiIdWidth;
  localparam int unsigned RunWidth = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [RunWidth-1:0] RunMax = RunWidth'(TimeoutCycles);

  typedef enum logic [1:0] {
    StDisarmed,
    StArmed,
    StTriggered
  } state_e;

  state_e                       state_q, state_d;
  logic [4:0][CntWidth-1:0]     cnt_q, cnt_d;
  logic                         fv_q, fv_d;
  logic [2:0]                   fchan_q, fchan_d;
  logic [AxiIdWidth-1:0]        fid_q, fid_d;
  logic [TimeWidth-1:0]         ftime_q, ftime_d;
  logic [TimeWidth-1:0]         ts_q, ts_d;
  logic                         irq_q, irq_d;
  logic                         hang_q, hang_d;
  logic [RunWidth-1:0]          run_q, run_d;
  logic                         rec;
  logic [4:0]                   ev;

  function automatic logic [AxiIdWidth-1:0] lowest_set(input logic [NumIds-1:0] v);
    logic [AxiIdWidth-1:0] idx;
    idx = '0;
    for (int i = NumIds - 1; i >= 0; i--) begin
      if (v[i]) idx = AxiIdWidth'(i);
    end
    return idx;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fv_d    = fv_q;
    fchan_d = fchan_q;
    fid_d   = fid_q;
    ftime_d = ftime_q;
    ts_d    = ts_q;
    irq_d   = irq_q;
    hang_d  = hang_q;
    run_d   = run_q;

    // Bit order of ev is the channel code, so the lowest set bit wins capture.
    rec = enable_i && (state_q != StDisarmed);
    ev  = {|r_mismatch_i, |ar_mismatch_i, |b_mismatch_i, w_mismatch_i, |aw_mismatch_i}
          & {5{rec}};

    unique case (state_q)
      StDisarmed:  if (enable_i) state_d = fv_q ? StTriggered : StArmed;
      StArmed: begin
        if (!enable_i) state_d = StDisarmed;
        else if (|ev)  state_d = StTriggered;
      end
      StTriggered: if (!enable_i) state_d = StDisarmed;
      default:     state_d = StDisarmed;
    endcase

    for (int c = 0; c < 5; c++) begin
      if (ev[c] && cnt_q[c] != '1) cnt_d[c] = cnt_q[c] + 1'b1;
    end

    if (|ev) irq_d = 1'b1;

    if (state_q == StArmed && |ev) begin
      fv_d    = 1'b1;
      ftime_d = ts_q;
      if (ev[0]) begin
        fchan_d = 3'd0;
        fid_d   = lowest_set(aw_mismatch_i);
      end else if (ev[1]) begin
        fchan_d = 3'd1;
        fid_d   = '0;
      end else if (ev[2]) begin
        fchan_d = 3'd2;
        fid_d   = lowest_set(b_mismatch_i);
      end else if (ev[3]) begin
        fchan_d = 3'd3;
        fid_d   = lowest_set(ar_mismatch_i);
      end else begin
        fchan_d = 3'd4;
        fid_d   = lowest_set(r_mismatch_i);
      end
    end

    if (enable_i && ts_q != '1) ts_d = ts_q + 1'b1;

    // Watchdog runs independently of enable; the run counter stops at the threshold.
    if (busy_i) begin
      if (run_q < RunMax) run_d = run_q + 1'b1;
      if (TimeoutCycles != 0 && run_d == RunMax) hang_d = 1'b1;
    end else begin
      run_d = '0;
    end

    if (clear_i) begin
      state_d = enable_i ? StArmed : StDisarmed;
      cnt_d   = '0;
      fv_d    = 1'b0;
      fchan_d = '0;
      fid_d   = '0;
      ftime_d = '0;
      ts_d    = '0;
      irq_d   = 1'b0;
      hang_d  = 1'b0;
      run_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StDisarmed;
      cnt_q   <= '0;
      fv_q    <= 1'b0;
      fchan_q <= '0;
      fid_q   <= '0;
      ftime_q <= '0;
      ts_q    <= '0;
      irq_q   <= 1'b0;
      hang_q  <= 1'b0;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fv_q    <= fv_d;
      fchan_q <= fchan_d;
      fid_q   <= fid_d;
      ftime_q <= ftime_d;
      ts_q    <= ts_d;
      irq_q   <= irq_d;
      hang_q  <= hang_d;
      run_q   <= run_d;
    end
  end

  assign aw_cnt_o      = cnt_q[0];
  assign w_cnt_o       = cnt_q[1];
  assign b_cnt_o       = cnt_q[2];
  assign ar_cnt_o      = cnt_q[3];
  assign r_cnt_o       = cnt_q[4];
  assign first_valid_o = fv_q;
  assign first_chan_o  = fchan_q;
  assign first_id_o    = fid_q;
  assign first_time_o  = ftime_q;
  assign irq_o         = irq_q;
  assign hang_o        = hang_q;

endmodule
